// File: rtl/v_wb_seq_pkg.sv
// ---------------------------------------------------------------------------
// vwb_pkg
// Shared definitions for the v_wb_seq write-back sequencer: FSM state type,
// lmul encodings, vector register geometry and the lmul-to-register-count
// decode used when a result group is captured.
// ---------------------------------------------------------------------------
package vwb_pkg;

   // Sequencer states: waiting for results, or streaming beats to the VRF
   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_e;

   // lmul encodings understood by the sequencer
   localparam logic [2:0] LMUL_1 = 3'b000;
   localparam logic [2:0] LMUL_2 = 3'b001;
   localparam logic [2:0] LMUL_4 = 3'b010;

   // Bytes per vector register and largest register group handled
   localparam int VLEN_BYTES = 16;
   localparam int NREG_MAX   = 4;

   // Number of registers written for a given lmul; unknown codes write the
   // largest group so no result slot is ever silently discarded
   function automatic logic [2:0] lmulToNregs(input logic [2:0] lmul);
      logic [2:0] n;
      case (lmul)
         LMUL_1:  n = 3'd1;
         LMUL_2:  n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/v_wb_seq_if.sv
// ---------------------------------------------------------------------------
// v_wb_seq_if
// VRF write-port bundle between the write-back sequencer (master) and the
// vector register file (slave).
//   wb_valid / wb_ready : beat handshake
//   wb_addr             : destination register
//   wb_data             : register-wide write data
//   wb_last             : final beat of the current group
//   wb_done             : one-cycle pulse after the final beat is accepted
//   wb_be               : byte enables (only with VWB_TAIL_MASK_EN defined)
// ---------------------------------------------------------------------------
interface v_wb_seq_if #(
   parameter int VLEN = 128
);

   logic            wb_valid;
   logic            wb_ready;
   logic [4:0]      wb_addr;
   logic [VLEN-1:0] wb_data;
   logic            wb_last;
   logic            wb_done;
`ifdef VWB_TAIL_MASK_EN
   logic [15:0]     wb_be;
`endif

   // Sequencer side: drives the beat, samples the VRF's ready
   modport master (
      output wb_valid,
      output wb_addr,
      output wb_data,
      output wb_last,
      output wb_done,
`ifdef VWB_TAIL_MASK_EN
      output wb_be,
`endif
      input  wb_ready
   );

   // Register-file side
   modport slave (
      input  wb_valid,
      input  wb_addr,
      input  wb_data,
      input  wb_last,
      input  wb_done,
`ifdef VWB_TAIL_MASK_EN
      input  wb_be,
`endif
      output wb_ready
   );

endinterface

// File: rtl/v_wb_seq_tail_mask.sv
// ---------------------------------------------------------------------------
// vwb_tail_mask
// Combinational byte-enable generator for one write-back beat. Byte b of beat
// beatIdx_i is enabled when its position in the register group lies below
// the active byte count vl_i * (1 << vsew_i).
// Ports:
//   beatIdx_i : beat number within the group (0-based)
//   vsew_i    : element width code (0 = 8b, 1 = 16b, 2 = 32b)
//   vl_i      : active element count
//   be_o      : per-byte enables for the beat
// Only instantiated when VWB_TAIL_MASK_EN is defined.
// ---------------------------------------------------------------------------
module vwb_tail_mask
   import vwb_pkg::*;
(
   input  logic [2:0]  beatIdx_i,
   input  logic [2:0]  vsew_i,
   input  logic [6:0]  vl_i,
   output logic [15:0] be_o
);

   logic [15:0] activeBytes;
   logic [15:0] beatBase;

   // Compare each byte's absolute position in the group against the number
   // of active bytes; 16 bits is ample for vl=127 at any vsew code
   always_comb begin
      activeBytes = {9'd0, vl_i} << vsew_i;
      beatBase    = {13'd0, beatIdx_i} * 16'(VLEN_BYTES);
      be_o        = '0;
      for (int b = 0; b < 16; b++) begin
         be_o[b] = ((beatBase + 16'(b)) < activeBytes);
      end
   end

endmodule

// File: rtl/v_wb_seq.sv
// ---------------------------------------------------------------------------
// v_wb_seq
// Write-back sequencer: captures up to four lane results when the lane array
// pulses lanes_done, then streams them one register per beat to the VRF
// write port, wrapping the destination address past v31.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   lanes_done        : results valid this cycle (one-cycle pulse)
//   is_mul            : select multiplier (1) or ALU (0) results
//   lmul              : register group size code
//   vd                : destination base register
//   res_alu_1..4      : ALU result slots
//   res_mul_1..4      : multiplier result slots
//   vsew, vl          : element width / active length (VWB_TAIL_MASK_EN only)
//   busy              : group in progress
//   err_overrun       : sticky, a lanes_done pulse arrived while busy
//   wb                : VRF write port (master modport of v_wb_seq_if)
// Optional feature macro: VWB_TAIL_MASK_EN adds tail byte enables.
// ---------------------------------------------------------------------------
module v_wb_seq #(
   parameter int NREG_MAX = 4,
   parameter int VLEN     = 128
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            lanes_done,
   input  logic            is_mul,
   input  logic [2:0]      lmul,
   input  logic [4:0]      vd,
   input  logic [VLEN-1:0] res_alu_1,
   input  logic [VLEN-1:0] res_alu_2,
   input  logic [VLEN-1:0] res_alu_3,
   input  logic [VLEN-1:0] res_alu_4,
   input  logic [VLEN-1:0] res_mul_1,
   input  logic [VLEN-1:0] res_mul_2,
   input  logic [VLEN-1:0] res_mul_3,
   input  logic [VLEN-1:0] res_mul_4,
`ifdef VWB_TAIL_MASK_EN
   input  logic [2:0]      vsew,
   input  logic [6:0]      vl,
`endif
   output logic            busy,
   output logic            err_overrun,
   v_wb_seq_if.master      wb
);

   import vwb_pkg::*;

   state_e          state_q, state_d;
   logic [2:0]      beatIdx_q;
   logic [2:0]      nregs_q;
   logic [4:0]      addr_q;
   logic [VLEN-1:0] data_q;
   logic            last_q;
   logic            done_q;
   logic            errOverrun_q;
   logic [VLEN-1:0] slot_q  [NREG_MAX];
   logic [VLEN-1:0] selSlot [NREG_MAX];

   logic            capture;
   logic            handshake;
   logic            lastHandshake;
   logic [2:0]      nextIdx;
   logic [2:0]      nregsIn;

   assign capture       = (state_q == IDLE) && lanes_done;
   assign handshake     = (state_q == WRITE) && wb.wb_ready;
   assign lastHandshake = handshake && last_q;
   assign nextIdx       = beatIdx_q + 3'd1;
   assign nregsIn       = lmulToNregs(lmul);

   // Result source selection happens once, at capture time, so a later change
   // of is_mul cannot disturb a group already in flight
   always_comb begin
      for (int k = 0; k < NREG_MAX; k++) begin
         selSlot[k] = '0;
      end
      selSlot[0] = is_mul ? res_mul_1 : res_alu_1;
      selSlot[1] = is_mul ? res_mul_2 : res_alu_2;
      selSlot[2] = is_mul ? res_mul_3 : res_alu_3;
      selSlot[3] = is_mul ? res_mul_4 : res_alu_4;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: a pulse in IDLE starts a group, the accepted last beat
   // ends it
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (lanes_done) state_d = WRITE;
         WRITE:   if (lastHandshake) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic: valid and busy follow the state, the beat payload comes
   // straight from registers so it is glitch-free and holds during stalls
   always_comb begin
      busy        = (state_q == WRITE);
      wb.wb_valid = (state_q == WRITE);
      wb.wb_addr  = addr_q;
      wb.wb_data  = data_q;
      wb.wb_last  = last_q;
      wb.wb_done  = done_q;
      err_overrun = errOverrun_q;
   end

   // Result buffer; it is only written on an accepted capture, so pulses that
   // arrive mid-group leave the in-flight data untouched
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int k = 0; k < NREG_MAX; k++) begin
            slot_q[k] <= selSlot[k];
         end
      end
   end

   // Beat sequencing. The payload register is preloaded with the next beat on
   // each handshake so consecutive beats issue back-to-back; after the last
   // beat address and data simply hold their final values
   always_ff @(posedge clk) begin
      if (rst) begin
         beatIdx_q    <= '0;
         nregs_q      <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         last_q       <= 1'b0;
         done_q       <= 1'b0;
         errOverrun_q <= 1'b0;
      end else begin
         done_q <= lastHandshake;
         if (lanes_done && (state_q == WRITE)) begin
            errOverrun_q <= 1'b1;
         end
         if (capture) begin
            beatIdx_q <= '0;
            nregs_q   <= nregsIn;
            addr_q    <= vd;
            data_q    <= selSlot[0];
            last_q    <= (nregsIn == 3'd1);
         end else if (lastHandshake) begin
            beatIdx_q <= '0;
            last_q    <= 1'b0;
         end else if (handshake) begin
            beatIdx_q <= nextIdx;
            addr_q    <= addr_q + 5'd1;
            data_q    <= slot_q[nextIdx[1:0]];
            last_q    <= (nextIdx == (nregs_q - 3'd1));
         end
      end
   end

`ifdef VWB_TAIL_MASK_EN
   logic [2:0]  vsew_q;
   logic [6:0]  vl_q;
   logic [15:0] be_q;
   logic [2:0]  maskIdx;
   logic [2:0]  maskVsew;
   logic [6:0]  maskVl;
   logic [15:0] maskBe;

   // On capture the mask for beat 0 is built from the live inputs; later
   // beats use the copies captured with the buffer
   always_comb begin
      maskIdx  = capture ? 3'd0 : nextIdx;
      maskVsew = capture ? vsew : vsew_q;
      maskVl   = capture ? vl   : vl_q;
   end

   vwb_tail_mask uTailMask (
      .beatIdx_i (maskIdx),
      .vsew_i    (maskVsew),
      .vl_i      (maskVl),
      .be_o      (maskBe)
   );

   // Byte enables advance in lockstep with the data register
   always_ff @(posedge clk) begin
      if (rst) begin
         vsew_q <= '0;
         vl_q   <= '0;
         be_q   <= '0;
      end else if (capture) begin
         vsew_q <= vsew;
         vl_q   <= vl;
         be_q   <= maskBe;
      end else if (handshake && !last_q) begin
         be_q   <= maskBe;
      end
   end

   assign wb.wb_be = be_q;
`endif

endmodule

// File: tb/tb_v_wb_seq.sv
// ---------------------------------------------------------------------------
// tb_v_wb_seq
// Directed self-checking bench for the v_wb_seq write-back sequencer.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_v_wb_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic         lanes_done;
   logic         is_mul;
   logic [2:0]   lmul;
   logic [4:0]   vd;
   logic [127:0] res_alu_1, res_alu_2, res_alu_3, res_alu_4;
   logic [127:0] res_mul_1, res_mul_2, res_mul_3, res_mul_4;
   logic         busy;
   logic         err_overrun;
`ifdef VWB_TAIL_MASK_EN
   logic [2:0]   vsew;
   logic [6:0]   vl;
`endif

   int checks = 0;
   int errors = 0;

   v_wb_seq_if #(.VLEN(128)) wbIf ();

   v_wb_seq #(.NREG_MAX(4), .VLEN(128)) dut (
      .clk         (clk),
      .rst         (rst),
      .lanes_done  (lanes_done),
      .is_mul      (is_mul),
      .lmul        (lmul),
      .vd          (vd),
      .res_alu_1   (res_alu_1),
      .res_alu_2   (res_alu_2),
      .res_alu_3   (res_alu_3),
      .res_alu_4   (res_alu_4),
      .res_mul_1   (res_mul_1),
      .res_mul_2   (res_mul_2),
      .res_mul_3   (res_mul_3),
      .res_mul_4   (res_mul_4),
`ifdef VWB_TAIL_MASK_EN
      .vsew        (vsew),
      .vl          (vl),
`endif
      .busy        (busy),
      .err_overrun (err_overrun),
      .wb          (wbIf)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Advance one clock and land just after the edge
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // One comparison: counts it, and on mismatch counts and reports it
   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      logic [4:0]   expAddr;
      logic [127:0] expMul [4];

      rst        = 1'b1;
      lanes_done = 1'b0;
      is_mul     = 1'b0;
      lmul       = 3'b000;
      vd         = 5'd0;
      res_alu_1  = {16{8'hA5}};
      res_alu_2  = {16{8'hB6}};
      res_alu_3  = {16{8'hC7}};
      res_alu_4  = {16{8'hD8}};
      res_mul_1  = {4{32'h1111_0001}};
      res_mul_2  = {4{32'h2222_0002}};
      res_mul_3  = {4{32'h3333_0003}};
      res_mul_4  = {4{32'h4444_0004}};
      expMul[0]  = {4{32'h1111_0001}};
      expMul[1]  = {4{32'h2222_0002}};
      expMul[2]  = {4{32'h3333_0003}};
      expMul[3]  = {4{32'h4444_0004}};
      wbIf.wb_ready = 1'b0;
`ifdef VWB_TAIL_MASK_EN
      vsew = 3'd0;
      vl   = 7'd127;
`endif

      // Reset state
      #1;
      applyStimulus();
      applyStimulus();
      rst = 1'b0;
      checkOutput("rst_busy",  128'(busy), 128'(0));
      checkOutput("rst_valid", 128'(wbIf.wb_valid), 128'(0));
      checkOutput("rst_last",  128'(wbIf.wb_last), 128'(0));
      checkOutput("rst_done",  128'(wbIf.wb_done), 128'(0));
      checkOutput("rst_err",   128'(err_overrun), 128'(0));
      checkOutput("rst_addr",  128'(wbIf.wb_addr), 128'(0));
      checkOutput("rst_data",  wbIf.wb_data, 128'(0));

      // Single-register group, ALU results, ready always high
      lmul = 3'b000; is_mul = 1'b0; vd = 5'd5; wbIf.wb_ready = 1'b1;
      lanes_done = 1'b1;
      applyStimulus();
      lanes_done = 1'b0;
      checkOutput("t1_valid", 128'(wbIf.wb_valid), 128'(1));
      checkOutput("t1_busy",  128'(busy), 128'(1));
      checkOutput("t1_addr",  128'(wbIf.wb_addr), 128'(5));
      checkOutput("t1_data",  wbIf.wb_data, {16{8'hA5}});
      checkOutput("t1_last",  128'(wbIf.wb_last), 128'(1));
      applyStimulus();
      checkOutput("t1_valid_off", 128'(wbIf.wb_valid), 128'(0));
      checkOutput("t1_done",      128'(wbIf.wb_done), 128'(1));
      checkOutput("t1_addr_hold", 128'(wbIf.wb_addr), 128'(5));
      checkOutput("t1_data_hold", wbIf.wb_data, {16{8'hA5}});
      applyStimulus();
      checkOutput("t1_done_pulse", 128'(wbIf.wb_done), 128'(0));

      // Four-register multiplier group wrapping past v31; a lanes_done on the
      // final handshake cycle is dropped and flagged
      lmul = 3'b010; is_mul = 1'b1; vd = 5'd30;
      lanes_done = 1'b1;
      applyStimulus();
      lanes_done = 1'b0;
      for (int k = 0; k < 4; k++) begin
         expAddr = 5'd30 + 5'(k);
         checkOutput($sformatf("t2_valid%0d", k), 128'(wbIf.wb_valid), 128'(1));
         checkOutput($sformatf("t2_addr%0d", k),  128'(wbIf.wb_addr), 128'(expAddr));
         checkOutput($sformatf("t2_data%0d", k),  wbIf.wb_data, expMul[k]);
         checkOutput($sformatf("t2_last%0d", k),  128'(wbIf.wb_last), 128'(k == 3));
         if (k == 3) lanes_done = 1'b1;
         applyStimulus();
      end
      lanes_done = 1'b0;
      checkOutput("t2_valid_off", 128'(wbIf.wb_valid), 128'(0));
      checkOutput("t2_done",      128'(wbIf.wb_done), 128'(1));
      checkOutput("t2_err_final", 128'(err_overrun), 128'(1));
      applyStimulus();
      checkOutput("t2_no_restart", 128'(wbIf.wb_valid), 128'(0));

      rst = 1'b1;
      applyStimulus();
      rst = 1'b0;
      checkOutput("t2_err_clear", 128'(err_overrun), 128'(0));

      // Two-register group with ready pattern 0,0,1,0,1
      lmul = 3'b001; is_mul = 1'b0; vd = 5'd10; wbIf.wb_ready = 1'b0;
      lanes_done = 1'b1;
      applyStimulus();
      lanes_done = 1'b0;
      checkOutput("t3_addr_s0", 128'(wbIf.wb_addr), 128'(10));
      checkOutput("t3_data_s0", wbIf.wb_data, {16{8'hA5}});
      applyStimulus();
      checkOutput("t3_addr_s1", 128'(wbIf.wb_addr), 128'(10));
      checkOutput("t3_data_s1", wbIf.wb_data, {16{8'hA5}});
      checkOutput("t3_last_s1", 128'(wbIf.wb_last), 128'(0));
      wbIf.wb_ready = 1'b1;
      applyStimulus();
      wbIf.wb_ready = 1'b0;
      checkOutput("t3_addr_b1", 128'(wbIf.wb_addr), 128'(11));
      checkOutput("t3_data_b1", wbIf.wb_data, {16{8'hB6}});
      checkOutput("t3_last_b1", 128'(wbIf.wb_last), 128'(1));
      applyStimulus();
      checkOutput("t3_addr_s3", 128'(wbIf.wb_addr), 128'(11));
      checkOutput("t3_data_s3", wbIf.wb_data, {16{8'hB6}});
      checkOutput("t3_done_early", 128'(wbIf.wb_done), 128'(0));
      wbIf.wb_ready = 1'b1;
      applyStimulus();
      checkOutput("t3_valid_off", 128'(wbIf.wb_valid), 128'(0));
      checkOutput("t3_done",      128'(wbIf.wb_done), 128'(1));

      // Overrun while beat 1 of 2 is stalled: data must stay the original
      lmul = 3'b001; is_mul = 1'b0; vd = 5'd3; wbIf.wb_ready = 1'b0;
      lanes_done = 1'b1;
      applyStimulus();
      is_mul = 1'b1; vd = 5'd20;
      res_alu_1 = {16{8'h11}}; res_alu_2 = {16{8'h22}};
      applyStimulus();
      lanes_done = 1'b0;
      checkOutput("t4_err",   128'(err_overrun), 128'(1));
      checkOutput("t4_addr0", 128'(wbIf.wb_addr), 128'(3));
      checkOutput("t4_data0", wbIf.wb_data, {16{8'hA5}});
      wbIf.wb_ready = 1'b1;
      applyStimulus();
      checkOutput("t4_addr1", 128'(wbIf.wb_addr), 128'(4));
      checkOutput("t4_data1", wbIf.wb_data, {16{8'hB6}});
      applyStimulus();
      checkOutput("t4_done",       128'(wbIf.wb_done), 128'(1));
      checkOutput("t4_err_sticky", 128'(err_overrun), 128'(1));
      rst = 1'b1;
      applyStimulus();
      rst = 1'b0;
      checkOutput("t4_err_rst", 128'(err_overrun), 128'(0));

      // Reset during beat 2 of 4, then a normal group
      lmul = 3'b010; is_mul = 1'b1; vd = 5'd8; wbIf.wb_ready = 1'b1;
      lanes_done = 1'b1;
      applyStimulus();
      lanes_done = 1'b0;
      applyStimulus();
      checkOutput("t5_addr_b2", 128'(wbIf.wb_addr), 128'(9));
      rst = 1'b1;
      applyStimulus();
      rst = 1'b0;
      checkOutput("t5_valid", 128'(wbIf.wb_valid), 128'(0));
      checkOutput("t5_busy",  128'(busy), 128'(0));
      checkOutput("t5_done",  128'(wbIf.wb_done), 128'(0));
      applyStimulus();
      checkOutput("t5_done_after", 128'(wbIf.wb_done), 128'(0));
      lmul = 3'b000; is_mul = 1'b0; vd = 5'd9; res_alu_1 = {16{8'h5A}};
      lanes_done = 1'b1;
      applyStimulus();
      lanes_done = 1'b0;
      checkOutput("t5_new_addr", 128'(wbIf.wb_addr), 128'(9));
      checkOutput("t5_new_data", wbIf.wb_data, {16{8'h5A}});
      checkOutput("t5_new_last", 128'(wbIf.wb_last), 128'(1));
      applyStimulus();
      checkOutput("t5_new_done", 128'(wbIf.wb_done), 128'(1));

      // Illegal lmul code behaves as a four-register group
      lmul = 3'b111; is_mul = 1'b1; vd = 5'd0;
      lanes_done = 1'b1;
      applyStimulus();
      lanes_done = 1'b0;
      applyStimulus();
      applyStimulus();
      applyStimulus();
      checkOutput("t6_addr3", 128'(wbIf.wb_addr), 128'(3));
      checkOutput("t6_last3", 128'(wbIf.wb_last), 128'(1));
      applyStimulus();
      checkOutput("t6_done", 128'(wbIf.wb_done), 128'(1));

`ifdef VWB_TAIL_MASK_EN
      // Tail mask: 5 elements of 32 bits span 20 bytes over two registers
      lmul = 3'b001; vsew = 3'd2; vl = 7'd5; vd = 5'd12;
      lanes_done = 1'b1;
      applyStimulus();
      lanes_done = 1'b0;
      checkOutput("t7_be0", 128'(wbIf.wb_be), 128'(16'hFFFF));
      applyStimulus();
      checkOutput("t7_be1", 128'(wbIf.wb_be), 128'(16'h000F));
      applyStimulus();
      // vl=0 still issues every beat with all bytes masked
      lmul = 3'b001; vsew = 3'd0; vl = 7'd0;
      lanes_done = 1'b1;
      applyStimulus();
      lanes_done = 1'b0;
      checkOutput("t7_vl0_valid", 128'(wbIf.wb_valid), 128'(1));
      checkOutput("t7_vl0_be",    128'(wbIf.wb_be), 128'(0));
      applyStimulus();
      checkOutput("t7_vl0_valid1", 128'(wbIf.wb_valid), 128'(1));
      applyStimulus();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
